// File: rtl/ex_stage_pkg.sv
// Shared types for the execute stage: operand widths and control enums.
package ex_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic              enable_t;
  typedef logic [REG_W-1:0]  reg_addr_t;

  typedef enum logic {SRC1_RS1, SRC1_PC} src1_sel_e;
  typedef enum logic {SRC2_RS2, SRC2_IMM} src2_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_PASS_B,
    ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef enum logic [2:0] {
    CMP_BEQ, CMP_BNE, CMP_BLT, CMP_BGE, CMP_BLTU, CMP_BGEU
  } cmp_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC_NEXT} wb_sel_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX operands, forwarding sources and EX/MEM-bound results of the execute stage.
interface ex_stage_if;
  import ex_stage_pkg::*;

  data_t     pc_i, rs1_data_i, rs2_data_i, imm_i, pc_next_i;
  enable_t   jump_c_i, branch_c_i, mem_write_c_i, reg_write_c_i;
  src1_sel_e alu_src1_sel_c_i;
  src2_sel_e alu_src2_sel_c_i;
  alu_op_e   alu_op_c_i;
  cmp_op_e   cmp_op_c_i;
  wb_sel_e   wb_data_sel_c_i;
  reg_addr_t rd_i, rs1_i, rs2_i;
  reg_addr_t mem_rd_i, wb_rd_i;
  enable_t   mem_reg_write_c_i, wb_reg_write_c_i;
  data_t     mem_data_i, wb_data_i;

  data_t     alu_result_o, store_data_o, redirect_pc_o, pc_next_o;
  logic      redirect_o, stall_o;
  reg_addr_t rd_o;
  wb_sel_e   wb_data_sel_c_o;
  enable_t   reg_write_c_o, mem_write_c_o;

  modport slave (
    input  pc_i, rs1_data_i, rs2_data_i, imm_i, pc_next_i,
           jump_c_i, branch_c_i, mem_write_c_i, reg_write_c_i,
           alu_src1_sel_c_i, alu_src2_sel_c_i, alu_op_c_i, cmp_op_c_i, wb_data_sel_c_i,
           rd_i, rs1_i, rs2_i, mem_rd_i, wb_rd_i, mem_reg_write_c_i, wb_reg_write_c_i,
           mem_data_i, wb_data_i,
    output alu_result_o, store_data_o, redirect_pc_o, pc_next_o, redirect_o, stall_o,
           rd_o, wb_data_sel_c_o, reg_write_c_o, mem_write_c_o
  );

  modport master (
    output pc_i, rs1_data_i, rs2_data_i, imm_i, pc_next_i,
           jump_c_i, branch_c_i, mem_write_c_i, reg_write_c_i,
           alu_src1_sel_c_i, alu_src2_sel_c_i, alu_op_c_i, cmp_op_c_i, wb_data_sel_c_i,
           rd_i, rs1_i, rs2_i, mem_rd_i, wb_rd_i, mem_reg_write_c_i, wb_reg_write_c_i,
           mem_data_i, wb_data_i,
    input  alu_result_o, store_data_o, redirect_pc_o, pc_next_o, redirect_o, stall_o,
           rd_o, wb_data_sel_c_o, reg_write_c_o, mem_write_c_o
  );

endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU/comparator, branch redirect,
// and a multi-cycle iterative shifter that stalls the front of the pipe.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 4
) (
  input logic      clk,
  input logic      rst_n,
  ex_stage_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [4:0] STEP_W  = 5'(SHIFT_STEP);

  logic [1:0] r_state, w_state_nxt;
  data_t      r_val, w_val_nxt;
  logic [4:0] r_rem, w_rem_nxt;
  alu_op_e    r_op, w_op_nxt;

  data_t      w_rs1, w_rs2, w_src1, w_src2, w_sum, w_alu;
  logic [4:0] w_shamt, w_step;
  logic       w_is_shift, w_cmp_true, w_stall;

  // Operand forwarding: the younger producer (MEM) wins over WB; x0 never forwards.
  always_comb begin
    w_rs1 = bus.rs1_data_i;
    if (bus.mem_reg_write_c_i && bus.mem_rd_i == bus.rs1_i && bus.rs1_i != '0)
      w_rs1 = bus.mem_data_i;
    else if (bus.wb_reg_write_c_i && bus.wb_rd_i == bus.rs1_i && bus.rs1_i != '0)
      w_rs1 = bus.wb_data_i;

    w_rs2 = bus.rs2_data_i;
    if (bus.mem_reg_write_c_i && bus.mem_rd_i == bus.rs2_i && bus.rs2_i != '0)
      w_rs2 = bus.mem_data_i;
    else if (bus.wb_reg_write_c_i && bus.wb_rd_i == bus.rs2_i && bus.rs2_i != '0)
      w_rs2 = bus.wb_data_i;
  end

  assign w_src1     = (bus.alu_src1_sel_c_i == SRC1_PC)  ? bus.pc_i  : w_rs1;
  assign w_src2     = (bus.alu_src2_sel_c_i == SRC2_IMM) ? bus.imm_i : w_rs2;
  assign w_sum      = w_src1 + w_src2;
  assign w_shamt    = w_src2[4:0];
  assign w_is_shift = (bus.alu_op_c_i == ALU_SLL) || (bus.alu_op_c_i == ALU_SRL) ||
                      (bus.alu_op_c_i == ALU_SRA);

  // Branch condition always looks at the register operands, never the ALU sources.
  always_comb begin
    w_cmp_true = 1'b0;
    case (bus.cmp_op_c_i)
      CMP_BEQ:  w_cmp_true = (w_rs1 == w_rs2);
      CMP_BNE:  w_cmp_true = (w_rs1 != w_rs2);
      CMP_BLT:  w_cmp_true = ($signed(w_rs1) <  $signed(w_rs2));
      CMP_BGE:  w_cmp_true = ($signed(w_rs1) >= $signed(w_rs2));
      CMP_BLTU: w_cmp_true = (w_rs1 <  w_rs2);
      CMP_BGEU: w_cmp_true = (w_rs1 >= w_rs2);
      default:  w_cmp_true = 1'b0;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (bus.alu_op_c_i)
      ALU_ADD:    w_alu = w_sum;
      ALU_SUB:    w_alu = w_src1 - w_src2;
      ALU_SLT:    w_alu = {31'b0, $signed(w_src1) < $signed(w_src2)};
      ALU_SLTU:   w_alu = {31'b0, w_src1 < w_src2};
      ALU_XOR:    w_alu = w_src1 ^ w_src2;
      ALU_OR:     w_alu = w_src1 | w_src2;
      ALU_AND:    w_alu = w_src1 & w_src2;
      ALU_PASS_B: w_alu = w_src2;
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu = (w_shamt == '0) ? w_src1 : r_val;
      default:    w_alu = '0;
    endcase
  end

  assign w_step = (r_rem < STEP_W) ? r_rem : STEP_W;

  // Shifter FSM next-state: latch in IDLE, step in SHIFT, present result in DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_val_nxt   = r_val;
    w_rem_nxt   = r_rem;
    w_op_nxt    = r_op;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_shift && w_shamt != '0) begin
          w_val_nxt   = w_src1;
          w_rem_nxt   = w_shamt;
          w_op_nxt    = bus.alu_op_c_i;
          w_stall     = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_stall = 1'b1;
        case (r_op)
          ALU_SLL: w_val_nxt = r_val << w_step;
          ALU_SRL: w_val_nxt = r_val >> w_step;
          default: w_val_nxt = data_t'($signed(r_val) >>> w_step);
        endcase
        w_rem_nxt = r_rem - w_step;
        if (r_rem == w_step) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_val   <= '0;
      r_rem   <= '0;
      r_op    <= ALU_ADD;
    end else begin
      r_state <= w_state_nxt;
      r_val   <= w_val_nxt;
      r_rem   <= w_rem_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // Reset gates the combinational controls so the pipe sees a bubble immediately.
  assign bus.stall_o         = w_stall & rst_n;
  assign bus.redirect_o      = rst_n & ~w_stall & (bus.jump_c_i | (bus.branch_c_i & w_cmp_true));
  assign bus.redirect_pc_o   = {w_sum[31:1], 1'b0};
  assign bus.alu_result_o    = (r_state == S_DONE) ? r_val : w_alu;
  assign bus.store_data_o    = w_rs2;
  assign bus.reg_write_c_o   = rst_n & ~w_stall & bus.reg_write_c_i;
  assign bus.mem_write_c_o   = rst_n & ~w_stall & bus.mem_write_c_i;
  assign bus.rd_o            = bus.rd_i;
  assign bus.pc_next_o       = bus.pc_next_i;
  assign bus.wb_data_sel_c_o = bus.wb_data_sel_c_i;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with an instruction-level reference model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int unsigned STEP = 4;

  typedef struct {
    data_t pc, rs1d, rs2d, imm, pcn, mem_data, wb_data;
    logic jump, branch, mw, rw, mem_rw, wb_rw;
    src1_sel_e s1; src2_sel_e s2; alu_op_e op; cmp_op_e cmp; wb_sel_e wbs;
    reg_addr_t rd, rs1, rs2, mem_rd, wb_rd;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ex_stage_if bus();

  ex_stage #(.SHIFT_STEP(STEP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Expectations for the current cycle, written by the driver, read by the checker.
  logic  cmp_en = 1'b0;
  logic  e_stall, e_res_v, e_redir, e_rw, e_mw, lit_res_en, lit_rd_en, lit_rd;
  data_t e_res, e_rpc, e_store, e_pcn, lit_res, lit_pc;
  reg_addr_t e_rd;
  wb_sel_e   e_wbs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall", 32'(bus.stall_o), 32'(e_stall));
      chk("reg_write", 32'(bus.reg_write_c_o), 32'(e_rw));
      chk("mem_write", 32'(bus.mem_write_c_o), 32'(e_mw));
      chk("redirect", 32'(bus.redirect_o), 32'(e_redir));
      chk("store_data", bus.store_data_o, e_store);
      chk("rd", 32'(bus.rd_o), 32'(e_rd));
      chk("pc_next", bus.pc_next_o, e_pcn);
      chk("wb_sel", 32'(bus.wb_data_sel_c_o), 32'(e_wbs));
      if (!e_stall) chk("redirect_pc", bus.redirect_pc_o, e_rpc);
      if (e_res_v) begin
        chk("result", bus.alu_result_o, e_res);
        if (lit_res_en) chk("lit_result", bus.alu_result_o, lit_res);
        if (lit_rd_en) begin
          chk("lit_redirect", 32'(bus.redirect_o), 32'(lit_rd));
          if (lit_rd) chk("lit_redirect_pc", bus.redirect_pc_o, lit_pc);
        end
      end
    end
  end

  function automatic ins_t nop();
    ins_t i;
    i.pc = '0; i.rs1d = '0; i.rs2d = '0; i.imm = '0; i.pcn = '0;
    i.mem_data = '0; i.wb_data = '0;
    i.jump = 0; i.branch = 0; i.mw = 0; i.rw = 0; i.mem_rw = 0; i.wb_rw = 0;
    i.s1 = SRC1_RS1; i.s2 = SRC2_RS2; i.op = ALU_ADD; i.cmp = CMP_BEQ; i.wbs = WB_ALU;
    i.rd = '0; i.rs1 = '0; i.rs2 = '0; i.mem_rd = '0; i.wb_rd = '0;
    return i;
  endfunction

  task automatic apply(input ins_t i);
    bus.pc_i = i.pc; bus.rs1_data_i = i.rs1d; bus.rs2_data_i = i.rs2d;
    bus.imm_i = i.imm; bus.pc_next_i = i.pcn;
    bus.jump_c_i = i.jump; bus.branch_c_i = i.branch;
    bus.mem_write_c_i = i.mw; bus.reg_write_c_i = i.rw;
    bus.alu_src1_sel_c_i = i.s1; bus.alu_src2_sel_c_i = i.s2;
    bus.alu_op_c_i = i.op; bus.cmp_op_c_i = i.cmp; bus.wb_data_sel_c_i = i.wbs;
    bus.rd_i = i.rd; bus.rs1_i = i.rs1; bus.rs2_i = i.rs2;
    bus.mem_rd_i = i.mem_rd; bus.mem_reg_write_c_i = i.mem_rw; bus.mem_data_i = i.mem_data;
    bus.wb_rd_i = i.wb_rd; bus.wb_reg_write_c_i = i.wb_rw; bus.wb_data_i = i.wb_data;
  endtask

  function automatic data_t fwd(input reg_addr_t rs, input data_t rf, input ins_t i);
    if (rs != 0 && i.mem_rw && i.mem_rd == rs) return i.mem_data;
    if (rs != 0 && i.wb_rw && i.wb_rd == rs) return i.wb_data;
    return rf;
  endfunction

  // Issue one instruction at posedge+1; holds it for the model-predicted occupancy.
  task automatic issue(input ins_t i, input logic scramble,
                       input logic lr_en, input data_t lr,
                       input logic ld_en, input logic ld, input data_t lpc);
    data_t a, b, x, y, res;
    logic taken;
    int sh, n;
    a = fwd(i.rs1, i.rs1d, i);
    b = fwd(i.rs2, i.rs2d, i);
    x = (i.s1 == SRC1_PC) ? i.pc : a;
    y = (i.s2 == SRC2_IMM) ? i.imm : b;
    sh = int'(y % 32);
    case (i.op)
      ALU_ADD:  res = x + y;
      ALU_SUB:  res = x - y;
      ALU_SLT:  res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      ALU_SLTU: res = (x < y) ? 32'd1 : 32'd0;
      ALU_XOR:  res = x ^ y;
      ALU_OR:   res = x | y;
      ALU_AND:  res = x & y;
      ALU_SLL:  res = x << sh;
      ALU_SRL:  res = x >> sh;
      ALU_SRA:  res = data_t'($signed(x) >>> sh);
      default:  res = y;
    endcase
    case (i.cmp)
      CMP_BEQ:  taken = (a == b);
      CMP_BNE:  taken = (a != b);
      CMP_BLT:  taken = ($signed(a) < $signed(b));
      CMP_BGE:  taken = ($signed(a) >= $signed(b));
      CMP_BLTU: taken = (a < b);
      default:  taken = (a >= b);
    endcase
    n = ((i.op == ALU_SLL || i.op == ALU_SRL || i.op == ALU_SRA) && sh != 0) ?
        (sh + int'(STEP) - 1) / int'(STEP) + 1 : 0;
    apply(i);
    lit_res_en = lr_en; lit_res = lr; lit_rd_en = ld_en; lit_rd = ld; lit_pc = lpc;
    for (int k = 0; k <= n; k++) begin
      if (scramble && k > 0) begin
        if (k < n) begin
          bus.rs1_data_i = $urandom; bus.imm_i = $urandom; bus.pc_i = $urandom;
        end else apply(i);
      end
      e_stall = (k < n);
      e_res_v = (k == n);
      e_res   = res;
      e_rw    = (k < n) ? 1'b0 : i.rw;
      e_mw    = (k < n) ? 1'b0 : i.mw;
      e_redir = (k < n) ? 1'b0 : (i.jump | (i.branch & taken));
      e_rpc   = (x + y) & ~32'h1;
      e_store = b;
      e_rd    = i.rd; e_pcn = i.pcn; e_wbs = i.wbs;
      cmp_en  = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
    end
    cmp_en = 1'b0;
  endtask

  ins_t t;

  initial begin
    // Reset holds every control output low even with live requests on the bus.
    t = nop(); t.rw = 1; t.mw = 1; t.jump = 1; t.op = ALU_SRA; t.s2 = SRC2_IMM; t.imm = 5;
    apply(t);
    #3;
    chk("rst_stall", 32'(bus.stall_o), 0);
    chk("rst_reg_write", 32'(bus.reg_write_c_o), 0);
    chk("rst_mem_write", 32'(bus.mem_write_c_o), 0);
    chk("rst_redirect", 32'(bus.redirect_o), 0);
    apply(nop());
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Forwarding priority: MEM beats WB beats regfile; x0 never forwards.
    t = nop(); t.rs1 = 5; t.rs1d = 32'h99; t.mem_rd = 5; t.mem_rw = 1; t.mem_data = 32'h11;
    t.wb_rd = 5; t.wb_rw = 1; t.wb_data = 32'h22; t.s2 = SRC2_IMM; t.imm = 1; t.rw = 1; t.rd = 7;
    issue(t, 0, 1, 32'h12, 0, 0, 0);
    t.mem_rw = 0;
    issue(t, 0, 1, 32'h23, 0, 0, 0);
    t.mem_rw = 1; t.rs1 = 0; t.rs1d = 0; t.mem_rd = 0; t.wb_rd = 0;
    issue(t, 0, 1, 32'h1, 0, 0, 0);

    // Store-data forwarding through rs2.
    t = nop(); t.rs2 = 3; t.rs2d = 32'h5; t.mem_rd = 3; t.mem_rw = 1; t.mem_data = 32'hCAFE;
    t.mw = 1; t.s2 = SRC2_IMM; t.imm = 8; t.rs1d = 32'h1000; t.pcn = 32'h44; t.wbs = WB_MEM;
    issue(t, 0, 1, 32'h1008, 0, 0, 0);

    // Plain ALU ops.
    t = nop(); t.rs1d = 32'd7; t.rs2d = 32'd9; t.rw = 1; t.rd = 9;
    t.op = ALU_SUB;  issue(t, 0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    t.rs1d = 32'hFFFF_FFFF; t.rs2d = 32'd1;
    t.op = ALU_SLT;  issue(t, 0, 1, 32'h1, 0, 0, 0);
    t.op = ALU_SLTU; issue(t, 0, 1, 32'h0, 0, 0, 0);
    t.rs1d = 32'hF0F0_1234; t.rs2d = 32'h0FF0_FF00;
    t.op = ALU_XOR;    issue(t, 0, 1, 32'hFF00_ED34, 0, 0, 0);
    t.op = ALU_OR;     issue(t, 0, 1, 32'hFFF0_FF34, 0, 0, 0);
    t.op = ALU_AND;    issue(t, 0, 1, 32'h00F0_1200, 0, 0, 0);
    t.op = ALU_PASS_B; issue(t, 0, 1, 32'h0FF0_FF00, 0, 0, 0);

    // Branches: signed vs unsigned compare on forwarded registers, target from pc+imm.
    t = nop(); t.rs1d = 32'hFFFF_FFFF; t.rs2d = 32'd1; t.pc = 32'h100; t.imm = 32'h20;
    t.s1 = SRC1_PC; t.s2 = SRC2_IMM; t.branch = 1; t.pcn = 32'h104;
    t.cmp = CMP_BLT;  issue(t, 0, 0, 0, 1, 1, 32'h120);
    t.cmp = CMP_BLTU; issue(t, 0, 0, 0, 1, 0, 0);
    t.cmp = CMP_BGEU; issue(t, 0, 0, 0, 1, 1, 32'h120);
    t.cmp = CMP_BGE;  issue(t, 0, 0, 0, 1, 0, 0);
    t.cmp = CMP_BNE;  issue(t, 0, 0, 0, 1, 1, 32'h120);
    t.cmp = CMP_BEQ;  issue(t, 0, 0, 0, 1, 0, 0);

    // JALR clears bit 0 of the computed target.
    t = nop(); t.rs1d = 32'h200; t.imm = 3; t.s2 = SRC2_IMM; t.jump = 1; t.rw = 1;
    t.wbs = WB_PC_NEXT;
    issue(t, 0, 1, 32'h203, 1, 1, 32'h202);

    // Zero-amount shift is single-cycle.
    t = nop(); t.rs1d = 32'h1234_5678; t.s2 = SRC2_IMM; t.imm = 0; t.op = ALU_SLL; t.rw = 1;
    issue(t, 0, 1, 32'h1234_5678, 0, 0, 0);

    // Multi-cycle shifts, operands disturbed after the latch cycle.
    t = nop(); t.rs1d = 32'h8000_0000; t.s2 = SRC2_IMM; t.imm = 31; t.op = ALU_SRA; t.rw = 1;
    issue(t, 1, 1, 32'hFFFF_FFFF, 0, 0, 0);
    t.rs1d = 32'h1; t.imm = 5; t.op = ALU_SLL;
    issue(t, 1, 1, 32'h20, 0, 0, 0);
    t.rs1d = 32'hF000_0000; t.imm = 8; t.op = ALU_SRL;
    issue(t, 1, 1, 32'h00F0_0000, 0, 0, 0);
    t.rs1d = 32'h4000_0000; t.imm = 4; t.op = ALU_SRA;
    issue(t, 1, 1, 32'h0400_0000, 0, 0, 0);

    // Reset in the third SHIFT cycle abandons the shift at once.
    t = nop(); t.rs1d = 32'h8000_0000; t.s2 = SRC2_IMM; t.imm = 31; t.op = ALU_SRA;
    t.rw = 1; t.mw = 1;
    apply(t);
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_stall_before", 32'(bus.stall_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(bus.stall_o), 0);
    chk("mid_rst_reg_write", 32'(bus.reg_write_c_o), 0);
    chk("mid_rst_mem_write", 32'(bus.mem_write_c_o), 0);
    apply(nop());
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    t = nop(); t.rs1d = 32'hA5A5_0000; t.s2 = SRC2_IMM; t.imm = 6; t.op = ALU_SRL; t.rw = 1;
    issue(t, 0, 1, 32'h0296_9400, 0, 0, 0);
    t = nop(); t.rs1d = 32'd3; t.s2 = SRC2_IMM; t.imm = 4;
    issue(t, 0, 1, 32'd7, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter SHIFT_STEP, default 4: maximum shift bits applied per SHIFT cycle (legal values 1, 2, 4, 8).
REQ-002 SHALL have input clk, 1 bit: the single clock; all state updates on posedge.
REQ-003 SHALL have input rst_n, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have inputs pc_i, rs1_data_i, rs2_data_i, imm_i, pc_next_i, each data_t (32 bits): operands from the ID/EX register.
REQ-005 SHALL have inputs jump_c_i, branch_c_i, mem_write_c_i, reg_write_c_i, each enable_t (1 bit): control from the ID/EX register.
REQ-006 SHALL have inputs alu_src1_sel_c_i (rs1|pc), alu_src2_sel_c_i (rs2|imm), alu_op_c_i, cmp_op_c_i and wb_data_sel_c_i, all package enums.
REQ-007 SHALL have inputs rd_i, rs1_i, rs2_i, each reg_addr_t (5 bits).
REQ-008 SHALL have inputs mem_rd_i (5), mem_reg_write_c_i (1) and mem_data_i (32): the EX/MEM forwarding source.
REQ-009 SHALL have inputs wb_rd_i (5), wb_reg_write_c_i (1) and wb_data_i (32): the WB forwarding source.
REQ-010 SHALL have outputs alu_result_o (32) and store_data_o (32): the ALU result and the forwarded rs2 value.
REQ-011 SHALL have outputs redirect_o (1) and redirect_pc_o (32): taken-branch or jump fetch redirect.
REQ-012 SHALL have output stall_o (1): holds PC, IF/ID and ID/EX registers.
REQ-013 SHALL have outputs rd_o, pc_next_o, wb_data_sel_c_o, reg_write_c_o and mem_write_c_o, passed to the EX/MEM register.

Function
REQ-014 SHALL forward each operand with priority MEM > WB > register file; a source matches only if its reg_write is 1, its rd equals the operand's rs, and that rs is not 0.
REQ-015 SHALL select src1 = pc_i or forwarded rs1, and src2 = imm_i or forwarded rs2, per the select enums.
REQ-016 SHALL compute ADD, SUB, SLT, SLTU, XOR, OR, AND and PASS_B combinationally in the same cycle; SLT/SLTU SHALL produce 32'h0/32'h1.
REQ-017 SHALL evaluate the comparator (BEQ, BNE, BLT, BGE, BLTU, BGEU) on forwarded rs1/rs2, independent of the src selects.
REQ-018 SHALL drive redirect_o = jump_c_i | (branch_c_i & cmp_true) and redirect_pc_o = adder result with bit 0 cleared; redirect_o SHALL be 0 whenever stall_o=1.
REQ-019 SHALL run SLL/SRL/SRA using shamt = src2[4:0]; shamt=0 SHALL complete combinationally (result = src1) with no stall.
REQ-020 SHALL implement FSM states IDLE, SHIFT and DONE for shifts with shamt≠0.
REQ-021 In IDLE with a shift op and shamt≠0, SHALL latch src1, shamt and op, assert stall_o, and go to SHIFT.
REQ-022 In SHIFT, SHALL shift by min(remaining, SHIFT_STEP) per cycle (SRA sign-filling), decrement remaining and assert stall_o, going to DONE when remaining reaches 0.
REQ-023 In DONE, SHALL drive alu_result_o = latched result with stall_o=0, then return to IDLE on the next edge.
REQ-024 Total EX occupancy for a shift SHALL be ceil(shamt/SHIFT_STEP)+2 cycles.
REQ-025 SHALL ignore forwarded and ID/EX operand changes after the IDLE latch cycle.
REQ-026 While stall_o=1, SHALL force reg_write_c_o=0 and mem_write_c_o=0 (bubble to EX/MEM); otherwise SHALL pass them through.
REQ-027 SHALL pass rd_o, pc_next_o and wb_data_sel_c_o through unchanged every cycle.

Reset
REQ-028 Asynchronous assertion of rst_n=0 SHALL immediately force the FSM to IDLE, clear latched operand, shamt and remaining registers to 0, and force stall_o, redirect_o, reg_write_c_o and mem_write_c_o to 0.
REQ-029 Reset during SHIFT SHALL abandon the shift; after deassertion, the first edge SHALL behave as IDLE.

Verification
REQ-030 Forwarding priority: rs1_i=5, mem_rd=5 with mem_data=0x11, wb_rd=5 with wb_data=0x22, op ADD, src2 imm=1 -> alu_result_o=0x12; with rs1_i=0 -> result = imm only.
REQ-031 SRA: src1=0x80000000, shamt=31, SHIFT_STEP=4 -> stall_o high 9 cycles, then DONE cycle result=0xFFFFFFFF, with reg_write_c_o=0 during stall.
REQ-032 SLL with shamt=0 -> result=src1 in the same cycle, stall_o never asserted.
REQ-033 BLT with rs1=-1, rs2=1 and pc=0x100, imm=0x20 -> redirect_o=1, redirect_pc_o=0x120; BLTU with the same operands -> redirect_o=0.
REQ-034 JALR target with computed sum 0x203 -> redirect_pc_o=0x202.
REQ-035 rst_n pulsed low in the third SHIFT cycle -> stall_o=0 immediately; the next shift starts cleanly from IDLE.
